// File: rtl/life_step_engine.sv
// life_step_engine: one in-place Game of Life generation
// over a ROWS x COLS board RAM with a 3-row window.
module life_step_engine #(
  parameter int COLS   = 40,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [COLS-1:0]   ram_wdata,
  output logic              ram_wren,
  input  logic [COLS-1:0]   ram_q,
  output logic              busy,
  output logic              done,
  output logic              stable,
  output logic [15:0]       generation,
  input  logic              gen_clear
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD0,
    S_CAP0,
    S_RD,
    S_CAP,
    S_WR,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ROWS - 1);

  state_t            state;
  logic [ADDR_W-1:0] r;
  logic [COLS-1:0]   prev;
  logic [COLS-1:0]   cur;
  logic [COLS-1:0]   nxt;
  logic              chg;
  logic [COLS-1:0]   nxt_in;
  logic [COLS-1:0]   new_row;

  // Bit i's left neighbour is bit i+1 (column 0 is the MSB);
  // zero-filled shifts make everything off the grid dead.
  function automatic logic [COLS-1:0] life_row(
    input logic [COLS-1:0] p,
    input logic [COLS-1:0] c,
    input logic [COLS-1:0] n
  );
    logic [COLS-1:0] res;
    logic [COLS-1:0] pl, pr, cl, cr, nl, nr;
    logic [3:0]      k;
    res = '0;
    pl  = p >> 1;
    pr  = p << 1;
    cl  = c >> 1;
    cr  = c << 1;
    nl  = n >> 1;
    nr  = n << 1;
    for (int i = 0; i < COLS; i++) begin
      k = {3'b0, pl[i]} + {3'b0, p[i]}
        + {3'b0, pr[i]} + {3'b0, cl[i]}
        + {3'b0, cr[i]} + {3'b0, nl[i]}
        + {3'b0, n[i]}  + {3'b0, nr[i]};
      res[i] = (k == 4'd3) | (c[i] & (k == 4'd2));
    end
    return res;
  endfunction

  // Row below the last one is dead; evaluate while capturing it.
  assign nxt_in  = (r < LAST) ? ram_q : '0;
  assign new_row = life_row(prev, cur, nxt_in);

  // Step sequencer with registered RAM port and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      r          <= '0;
      prev       <= '0;
      cur        <= '0;
      nxt        <= '0;
      chg        <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_wren   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      stable     <= 1'b0;
      generation <= '0;
    end else begin
      ram_wren <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            chg      <= 1'b0;
            r        <= '0;
            ram_addr <= '0;
            busy     <= 1'b1;
            state    <= S_RD0;
          end
        end
        S_RD0: state <= S_CAP0;
        S_CAP0: begin
          cur      <= ram_q;
          prev     <= '0;
          ram_addr <= r + ADDR_W'(1);
          state    <= S_RD;
        end
        S_RD: state <= S_CAP;
        S_CAP: begin
          nxt       <= nxt_in;
          ram_addr  <= r;
          ram_wdata <= new_row;
          ram_wren  <= 1'b1;
          state     <= S_WR;
        end
        S_WR: begin
          if (ram_wdata != cur) chg <= 1'b1;
          prev <= cur;
          cur  <= nxt;
          if (r == LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            r <= r + ADDR_W'(1);
            if (r + ADDR_W'(1) < LAST)
              ram_addr <= r + ADDR_W'(2);
            else
              ram_addr <= '0;
            state <= S_RD;
          end
        end
        S_DONE: begin
          stable     <= ~chg;
          generation <= generation + 16'd1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (gen_clear) generation <= '0;
    end
  end

endmodule

// File: tb/tb_life_step_engine.sv
// tb_life_step_engine: board RAM model, write scoreboard,
// table of seed boards plus protocol/reset sequences.
module tb_life_step_engine;
  localparam int COLS = 40;
  localparam int ROWS = 30;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            start = 1'b0;
  logic            gen_clear = 1'b0;
  logic [AW-1:0]   ram_addr;
  logic [COLS-1:0] ram_wdata;
  logic [COLS-1:0] ram_q;
  logic            ram_wren;
  logic            busy;
  logic            done;
  logic            stable;
  logic [15:0]     generation;

  logic            ld_en = 1'b0;
  logic [AW-1:0]   ld_a = '0;
  logic [COLS-1:0] ld_d = '0;

  logic [COLS-1:0] mem    [ROWS];
  logic [COLS-1:0] bd     [ROWS];
  logic [COLS-1:0] exp_bd [ROWS];
  logic            exp_st = 1'b0;
  logic [15:0]     exp_gen = '0;

  int errors = 0;
  int checks = 0;
  int busy_cnt = 0;
  int wren_cnt = 0;
  int done_cnt = 0;

  typedef struct {
    logic [AW-1:0]   a;
    logic [COLS-1:0] d;
  } wr_t;
  wr_t sbq[$];

  typedef struct {
    int              r0;
    int              n;
    logic [COLS-1:0] pat;
    int              cr;
    logic [COLS-1:0] cv;
    logic            st;
  } vec_t;
  vec_t tv[5];

  life_step_engine #(
    .COLS(COLS), .ROWS(ROWS), .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .ram_addr(ram_addr),
    .ram_wdata(ram_wdata),
    .ram_wren(ram_wren),
    .ram_q(ram_q),
    .busy(busy),
    .done(done),
    .stable(stable),
    .generation(generation),
    .gen_clear(gen_clear)
  );

  always #5 clk = ~clk;

  // Synchronous board RAM, one-cycle read latency.
  always @(posedge clk) begin
    ram_q <= mem[ram_addr];
    if (ld_en) mem[ld_a] <= ld_d;
    else if (ram_wren) mem[ram_addr] <= ram_wdata;
  end

  task automatic chk(input string nm,
                     input logic [COLS-1:0] act,
                     input logic [COLS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard: each write must match the next expected row.
  always @(negedge clk) begin
    if (reset_n) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (ram_wren) begin
        wr_t w;
        wren_cnt++;
        if (sbq.size() == 0) begin
          chk("unexpected_write", COLS'(ram_addr), '1);
        end else begin
          w = sbq.pop_front();
          chk("wr_addr", COLS'(ram_addr), COLS'(w.a));
          chk($sformatf("wr_data[%0d]", w.a), ram_wdata, w.d);
        end
      end
    end
  end

  // Reference generation computed cell by cell from the RAM.
  task automatic model();
    int n;
    int rr;
    int cc;
    logic al;
    exp_st = 1'b1;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if ((dr != 0 || dc != 0) && rr >= 0 && rr < ROWS &&
                cc >= 0 && cc < COLS)
              if (mem[rr][COLS-1-cc]) n++;
          end
        end
        al = mem[r][COLS-1-c];
        exp_bd[r][COLS-1-c] = (n == 3) || (al && n == 2);
      end
      if (exp_bd[r] !== mem[r]) exp_st = 1'b0;
    end
  endtask

  task automatic load();
    for (int i = 0; i < ROWS; i++) begin
      @(negedge clk);
      ld_en = 1'b1;
      ld_a  = AW'(i);
      ld_d  = bd[i];
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic arm();
    model();
    for (int i = 0; i < ROWS; i++)
      sbq.push_back('{a: AW'(i), d: exp_bd[i]});
    busy_cnt = 0;
    wren_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic run_step(input bit noisy, input bit clr);
    int k;
    arm();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (!done && k < 300) begin
      @(negedge clk);
      k++;
      if (noisy) start = (k == 10 || k == 50);
    end
    start = 1'b0;
    chk("latency", COLS'(k), COLS'(93));
    if (clr) gen_clear = 1'b1;
    @(negedge clk);
    gen_clear = 1'b0;
    exp_gen = clr ? 16'd0 : exp_gen + 16'd1;
    chk("done_pulse", COLS'(done), '0);
    chk("busy_end", COLS'(busy), '0);
    chk("busy_cycles", COLS'(busy_cnt), COLS'(92));
    chk("wren_cycles", COLS'(wren_cnt), COLS'(30));
    chk("done_cycles", COLS'(done_cnt), COLS'(1));
    chk("sb_left", COLS'(sbq.size()), '0);
    chk("generation", COLS'(generation), COLS'(exp_gen));
    chk("stable", COLS'(stable), COLS'(exp_st));
    for (int i = 0; i < ROWS; i++)
      chk($sformatf("row[%0d]", i), mem[i], exp_bd[i]);
    repeat (3) @(negedge clk);
    chk("no_requeue", COLS'(busy), '0);
  endtask

  task automatic rand_board();
    for (int i = 0; i < ROWS; i++)
      bd[i] = COLS'({$urandom(), $urandom()});
  endtask

  initial begin
    int k;
    tv[0] = '{13, 3, 40'h00_0008_0000,
              14, 40'h00_001C_0000, 1'b0};
    tv[1] = '{5, 2, 40'h00_3000_0000,
              5, 40'h00_3000_0000, 1'b1};
    tv[2] = '{0, 1, 40'hFF_FFFF_FFFF,
              1, 40'h7F_FFFF_FFFE, 1'b0};
    tv[3] = '{29, 1, 40'hFF_FFFF_FFFF,
              28, 40'h7F_FFFF_FFFE, 1'b0};
    tv[4] = '{0, 0, 40'h0, 0, 40'h0, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_addr", COLS'(ram_addr), '0);
    chk("rst_wdata", ram_wdata, '0);
    chk("rst_wren", COLS'(ram_wren), '0);
    chk("rst_busy", COLS'(busy), '0);
    chk("rst_done", COLS'(done), '0);
    chk("rst_stable", COLS'(stable), '0);
    chk("rst_gen", COLS'(generation), '0);
    reset_n = 1'b1;

    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < ROWS; i++) bd[i] = '0;
      for (int j = 0; j < tv[t].n; j++)
        bd[tv[t].r0 + j] = tv[t].pat;
      load();
      run_step(1'b0, 1'b0);
      chk($sformatf("tv%0d_row", t), mem[tv[t].cr], tv[t].cv);
      chk($sformatf("tv%0d_stable", t),
          COLS'(stable), COLS'(tv[t].st));
    end

    for (int i = 0; i < ROWS; i++) bd[i] = '0;
    for (int j = 13; j < 16; j++) bd[j] = 40'h00_0008_0000;
    load();
    run_step(1'b0, 1'b0);
    run_step(1'b0, 1'b0);
    chk("blink_r13", mem[13], 40'h00_0008_0000);
    chk("blink_r14", mem[14], 40'h00_0008_0000);
    chk("blink_r15", mem[15], 40'h00_0008_0000);

    rand_board();
    load();
    run_step(1'b1, 1'b0);

    @(negedge clk);
    gen_clear = 1'b1;
    @(negedge clk);
    gen_clear = 1'b0;
    exp_gen = '0;
    chk("idle_clear", COLS'(generation), '0);
    chk("idle_clear_st", COLS'(stable), COLS'(exp_st));

    rand_board();
    load();
    repeat (3) run_step(1'b0, 1'b0);
    chk("three_steps", COLS'(generation), COLS'(3));
    run_step(1'b0, 1'b1);
    chk("done_clear", COLS'(generation), '0);

    rand_board();
    load();
    arm();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (k < 40) begin
      @(negedge clk);
      k++;
    end
    reset_n = 1'b0;
    #1;
    sbq.delete();
    chk("mid_wren", COLS'(ram_wren), '0);
    chk("mid_busy", COLS'(busy), '0);
    chk("mid_done", COLS'(done), '0);
    chk("mid_stable", COLS'(stable), '0);
    chk("mid_gen", COLS'(generation), '0);
    for (int i = 0; i < ROWS; i++)
      chk($sformatf("part[%0d]", i), mem[i],
          (i < 12) ? exp_bd[i] : bd[i]);
    @(negedge clk);
    reset_n = 1'b1;
    exp_gen = '0;
    run_step(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
